adc_sequencer: RTL and testbench
================================

# adc_sequencer

Initiator-side sequencer for the 8-bit SAR ADC controller. It drives the controller's `go` request and consumes its `valid`/`result` handshake. A single `start` runs a burst of 2^AVG_LOG2 back-to-back conversions. The block returns the average, minimum and maximum of the burst, and flags a conversion that never completes. It sits between the system/register side and the SAR controller, which is unchanged.

## Interface
- WIDTH, 8, result width of the SAR controller.
- AVG_LOG2, 2, log2 of conversions per burst (N = 2^AVG_LOG2, legal 0..4).
- GAP, 2, minimum cycles `go` is held low between conversions (legal ≥1).
- TIMEOUT, 64, cycles `go` may stay high without `valid` before abort (legal ≥2).
- clk  in  1  system clock, all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  burst request, sampled only in IDLE.
- busy  out  1  high whenever state ≠ IDLE.
- done  out  1  one-cycle pulse at the end of each burst (normal or aborted).
- error  out  1  high when the last burst timed out; cleared by the next accepted start.
- avg  out  WIDTH  burst average, floor(sum / N).
- min_val  out  WIDTH  smallest result in the burst.
- max_val  out  WIDTH  largest result in the burst.
- go  out  1  conversion request to the SAR controller (registered).
- valid  in  1  conversion complete from the SAR controller.
- result  in  WIDTH  conversion value, qualified by `valid`.

## Operation
- Reset values: go=0, busy=0, done=0, error=0, avg=0, min_val=0, max_val=0. State is IDLE and all internal counters are 0.
- States: IDLE, CONV, GAP, FINISH.
- IDLE: go=0.
  - start=1 → clear acc, cnt and error; preset min to all-ones and max to 0; enter CONV.
  - start=0 → stay in IDLE.
- CONV: go=1; timer increments every cycle.
  - valid=1 → capture `result`. acc += result; update min/max; reset timer. If cnt == N−1, enter FINISH; otherwise cnt++ and enter GAP.
  - valid=0 with timer == TIMEOUT−1 → error=1, enter FINISH. The accumulator is discarded and the outputs avg/min_val/max_val keep their previous values.
- GAP: go=0; gap counter increments. Exit to CONV only when the counter has reached GAP and `valid` is low. A stale `valid` from the previous conversion therefore can never be captured twice.
- FINISH: done=1 for exactly this cycle. If error=0, load avg = acc >> AVG_LOG2, min_val = min and max_val = max. Then return to IDLE.
- Arithmetic:
  - acc is WIDTH+AVG_LOG2 bits and cannot overflow.
  - avg truncates (floor).
  - Comparisons are unsigned.
  - With AVG_LOG2=0, avg = min_val = max_val = the single result.
- start while busy is ignored; it is neither queued nor able to restart the burst.
- rst at any point forces go=0 immediately (asynchronously) and returns all outputs to their reset values. The controller then sees `go` fall, which is its own restart condition.
- Outputs avg/min_val/max_val are stable between FINISH cycles.

## Timing
- start high at edge k → CONV from edge k; go=1 and busy=1 are visible after edge k.
- valid sampled high at edge m → result captured at m; go=0 after m.
- Next go=1 rises no earlier than GAP cycles after m, and only after `valid` has been sampled low.
- After the last capture at edge m: done=1 and the new avg/min/max are registered out after edge m+1. done drops and busy=0 after edge m+2.
- Timeout: with go high from edge k and valid never high, error=1 and done=1 are visible after edge k+TIMEOUT+1.
- Minimum burst length for a controller with conversion latency L: N·(L+1) + (N−1)·GAP + 2 cycles.

## Test plan
- Model returns constant 0x46 for every conversion; N=4; pulse start → four go pulses, each followed by go low for ≥2 cycles; done once; avg=0x46, min_val=0x46, max_val=0x46, error=0.
- Model returns 0x10, 0x20, 0x30, 0x41 in order → sum 0xA1, avg=0x28, min_val=0x10, max_val=0x41.
- Model returns 0xFF four times → acc=0x3FC, avg=0xFF with no wrap. Then a burst of 0x00 ×4 → avg=0x00, min_val=0x00, max_val=0x00.
- Model never asserts valid → after 64 cycles of go high: error=1, done pulse, go=0. avg/min/max keep the prior burst's values. Next start clears error.
- Model holds valid high through the GAP window → sequencer waits in GAP with go=0 until valid falls; each result is counted exactly once.
- Assert rst during the second CONV of a burst → go=0 in the same cycle; all outputs zero; no done. Then start with results 0x46 ×4 → avg=0x46 with a clean count.

Source files
------------

// File: rtl/adc_sequencer_if.sv
// Handshake between the sequencer (master) and the 8-bit SAR ADC controller (slave).
// The master raises go and the slave answers with valid/result.
interface adc_sequencer_if #(
    parameter int WIDTH = 8
);
    logic             go;
    logic             valid;
    logic [WIDTH-1:0] result;

    modport master (output go, input valid, input result);
    modport slave  (input go, output valid, output result);
endinterface

// File: rtl/adc_sequencer.sv
// Burst sequencer for the SAR ADC controller: runs 2^AVG_LOG2 conversions per start
// and reports floor-average, min and max, or flags a conversion that never completed.
module adc_sequencer #(
    parameter int WIDTH    = 8,
    parameter int AVG_LOG2 = 2,
    parameter int GAP      = 2,
    parameter int TIMEOUT  = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [WIDTH-1:0] avg,
    output logic [WIDTH-1:0] min_val,
    output logic [WIDTH-1:0] max_val,
    adc_sequencer_if.master  sar
);

    localparam int N  = 1 << AVG_LOG2;
    localparam int AW = WIDTH + AVG_LOG2;
    localparam int CW = AVG_LOG2 + 1;
    localparam int TW = $clog2(TIMEOUT);
    localparam int GW = $clog2(GAP + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CONV,
        S_GAP,
        S_FINISH
    } state_t;

    state_t state, state_next;

    logic [AW-1:0]    acc;
    logic [CW-1:0]    cnt;
    logic [TW-1:0]    timer;
    logic [GW-1:0]    gap_cnt;
    logic [WIDTH-1:0] min_r;
    logic [WIDTH-1:0] max_r;
    logic             timed_out;

    logic accept, capture, timeout, last, gap_done;

    // done is high for the cycle after FINISH, so busy covers it and start is held off.
    assign busy     = (state != S_IDLE) || done;
    assign accept   = (state == S_IDLE) && start && !done;
    assign capture  = (state == S_CONV) && sar.valid;
    assign timeout  = (state == S_CONV) && !sar.valid && (timer == TW'(TIMEOUT - 1));
    assign last     = (cnt == CW'(N - 1));
    assign gap_done = (gap_cnt >= GW'(GAP - 1));

    // NOTE: asynchronous reset must appear in the sensitivity list, otherwise it synthesises as synchronous.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    // NOTE: default assignment first so every path assigns state_next and no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (accept) state_next = S_CONV;
            S_CONV: begin
                if (capture)      state_next = last ? S_FINISH : S_GAP;
                else if (timeout) state_next = S_FINISH;
            end
            // A valid still high from the last conversion must drop before the next go.
            S_GAP:    if (gap_done && !sar.valid) state_next = S_CONV;
            S_FINISH: state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // NOTE: non-blocking assignments keep every register sampling pre-edge values of the others.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sar.go    <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            avg       <= '0;
            min_val   <= '0;
            max_val   <= '0;
            acc       <= '0;
            cnt       <= '0;
            timer     <= '0;
            gap_cnt   <= '0;
            min_r     <= '0;
            max_r     <= '0;
            timed_out <= 1'b0;
        end else begin
            sar.go <= (state_next == S_CONV);
            done   <= (state == S_FINISH);
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        acc       <= '0;
                        cnt       <= '0;
                        timer     <= '0;
                        gap_cnt   <= '0;
                        min_r     <= '1;
                        max_r     <= '0;
                        error     <= 1'b0;
                        timed_out <= 1'b0;
                    end
                end
                S_CONV: begin
                    if (capture) begin
                        acc     <= acc + AW'(sar.result);
                        timer   <= '0;
                        gap_cnt <= '0;
                        if (sar.result < min_r) min_r <= sar.result;
                        if (sar.result > max_r) max_r <= sar.result;
                        if (!last) cnt <= cnt + 1'b1;
                    end else if (timeout) begin
                        timed_out <= 1'b1;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_GAP: begin
                    if (gap_cnt != GW'(GAP)) gap_cnt <= gap_cnt + 1'b1;
                end
                S_FINISH: begin
                    // An aborted burst leaves the previous results on the outputs.
                    if (timed_out) begin
                        error <= 1'b1;
                    end else begin
                        avg     <= acc[AW-1:AVG_LOG2];
                        min_val <= min_r;
                        max_val <= max_r;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_adc_sequencer.sv
// Directed bench for adc_sequencer with a behavioural SAR controller model
// (fixed latency, optional stuck-high valid, optional no-response).
module tb_adc_sequencer;

    localparam int LAT = 3;

    logic       clk;
    logic       rst;
    logic       start;
    logic       busy;
    logic       done;
    logic       error;
    logic [7:0] avg;
    logic [7:0] min_val;
    logic [7:0] max_val;

    adc_sequencer_if #(.WIDTH(8)) bus ();

    adc_sequencer #(
        .WIDTH(8), .AVG_LOG2(2), .GAP(2), .TIMEOUT(64)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .error(error),
        .avg(avg), .min_val(min_val), .max_val(max_val), .sar(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Controller model configuration (written only by the stimulus process).
    logic [7:0] vals [4];
    int         hold_n = 0;
    bit         never  = 1'b0;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Controller model: valid after LAT cycles of go, optionally held high afterwards.
    int lat = 0;
    int idx = 0;
    int hold_left = 0;
    bit m_prev_busy = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            bus.valid   = 1'b0;
            bus.result  = '0;
            lat         = 0;
            hold_left   = 0;
            m_prev_busy = 1'b0;
        end else begin
            if (busy && !m_prev_busy) idx = 0;
            m_prev_busy = busy;
            if (bus.go) begin
                if (!never && lat == LAT - 1) begin
                    bus.valid  = 1'b1;
                    bus.result = vals[idx];
                    idx        = (idx + 1) % 4;
                    hold_left  = hold_n;
                end else begin
                    bus.valid = 1'b0;
                end
                lat++;
            end else begin
                lat = 0;
                if (hold_left > 0) hold_left--;
                else bus.valid = 1'b0;
            end
        end
    end

    // Monitor: go pulses, go-low gaps, handshake and done timing.
    int burst_pulses = 0;
    int min_low      = 1000;
    int low_run      = 0;
    int rise_cyc     = 0;
    int cap_edge     = 0;
    int done_cyc     = 0;
    int done_cnt     = 0;
    int viol         = 0;
    bit prev_go      = 1'b0;
    bit prev_valid   = 1'b0;
    bit prev_busy    = 1'b0;
    always @(negedge clk) begin
        #1;
        if (busy && !prev_busy) begin
            burst_pulses = 0;
            min_low      = 1000;
        end
        if (bus.go && !prev_go) begin
            if (burst_pulses > 0 && low_run < min_low) min_low = low_run;
            burst_pulses++;
            low_run  = 0;
            rise_cyc = cyc;
            if (prev_valid) viol++;
        end
        if (!bus.go) low_run++;
        if (bus.go && bus.valid) cap_edge = cyc + 1;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        prev_go    = bus.go;
        prev_valid = bus.valid;
        prev_busy  = busy;
    end

    task automatic wait_done(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
        #2;
    endtask

    task automatic run_burst(input string tag,
                             input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] c, input logic [7:0] d,
                             input int hold_cycles, input bit no_valid, input bit poke,
                             input logic [7:0] e_avg, input logic [7:0] e_min,
                             input logic [7:0] e_max, input logic e_err, input int e_pulses);
        int dc0;
        @(negedge clk);
        #3;
        vals[0] = a; vals[1] = b; vals[2] = c; vals[3] = d;
        hold_n  = hold_cycles;
        never   = no_valid;
        dc0     = done_cnt;
        start   = 1'b1;
        @(posedge clk);
        #1;
        check({tag, "_go_after_start"}, 32'(bus.go), 32'd1);
        check({tag, "_busy_after_start"}, 32'(busy), 32'd1);
        check({tag, "_error_cleared"}, 32'(error), 32'd0);
        @(negedge clk);
        start = 1'b0;
        if (poke) begin
            repeat (5) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        wait_done(tag);
        check({tag, "_avg"}, 32'(avg), 32'(e_avg));
        check({tag, "_min"}, 32'(min_val), 32'(e_min));
        check({tag, "_max"}, 32'(max_val), 32'(e_max));
        check({tag, "_error"}, 32'(error), 32'(e_err));
        check({tag, "_busy_at_done"}, 32'(busy), 32'd1);
        check({tag, "_go_at_done"}, 32'(bus.go), 32'd0);
        check({tag, "_go_pulses"}, 32'(burst_pulses), 32'(e_pulses));
        if (e_pulses > 1) check({tag, "_gap_ge2"}, 32'(min_low >= 2), 32'd1);
        if (e_err) check({tag, "_timeout_lat"}, 32'(done_cyc - rise_cyc), 32'd65);
        else       check({tag, "_done_lat"}, 32'(done_cyc - cap_edge), 32'd1);
        @(negedge clk);
        #2;
        check({tag, "_done_drop"}, 32'(done), 32'd0);
        check({tag, "_busy_drop"}, 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        check({tag, "_done_once"}, 32'(done_cnt - dc0), 32'd1);
    endtask

    initial begin
        start = 1'b0;
        rst   = 1'b1;
        vals[0] = 8'h00; vals[1] = 8'h00; vals[2] = 8'h00; vals[3] = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_go", 32'(bus.go), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_avg", 32'(avg), 32'd0);
        check("rst_min", 32'(min_val), 32'd0);
        check("rst_max", 32'(max_val), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Constant input, with a start pulse mid-burst that must be ignored.
        run_burst("const46", 8'h46, 8'h46, 8'h46, 8'h46, 0, 1'b0, 1'b1,
                  8'h46, 8'h46, 8'h46, 1'b0, 4);
        // Full scale: acc = 0x3FC, no wrap.
        run_burst("allff", 8'hFF, 8'hFF, 8'hFF, 8'hFF, 0, 1'b0, 1'b0,
                  8'hFF, 8'hFF, 8'hFF, 1'b0, 4);
        run_burst("all00", 8'h00, 8'h00, 8'h00, 8'h00, 0, 1'b0, 1'b0,
                  8'h00, 8'h00, 8'h00, 1'b0, 4);
        // Sum 0xA1 -> floor(161/4) = 40.
        run_burst("ramp", 8'h10, 8'h20, 8'h30, 8'h41, 0, 1'b0, 1'b0,
                  8'h28, 8'h10, 8'h41, 1'b0, 4);
        // No response: error set, prior results retained.
        run_burst("timeout", 8'h99, 8'h99, 8'h99, 8'h99, 0, 1'b1, 1'b0,
                  8'h28, 8'h10, 8'h41, 1'b1, 1);
        // valid stuck high through GAP; sum 0x102 -> 64.
        run_burst("hold", 8'h80, 8'h01, 8'h7F, 8'h02, 4, 1'b0, 1'b0,
                  8'h40, 8'h01, 8'h80, 1'b0, 4);
        check("hold_no_go_while_valid", 32'(viol), 32'd0);

        // Reset during the second conversion of a burst.
        begin
            int  dc0;
            bit  hit = 1'b0;
            @(negedge clk);
            #3;
            vals[0] = 8'h46; vals[1] = 8'h46; vals[2] = 8'h46; vals[3] = 8'h46;
            hold_n = 0;
            never  = 1'b0;
            dc0    = done_cnt;
            start  = 1'b1;
            @(negedge clk);
            start = 1'b0;
            for (int i = 0; i < 200; i++) begin
                @(negedge clk);
                #2;
                if (burst_pulses == 2 && bus.go) begin
                    hit = 1'b1;
                    break;
                end
            end
            check("rstmid_reached_conv2", 32'(hit), 32'd1);
            rst = 1'b1;
            #1;
            check("rstmid_go", 32'(bus.go), 32'd0);
            check("rstmid_busy", 32'(busy), 32'd0);
            check("rstmid_done", 32'(done), 32'd0);
            check("rstmid_error", 32'(error), 32'd0);
            check("rstmid_avg", 32'(avg), 32'd0);
            check("rstmid_min", 32'(min_val), 32'd0);
            check("rstmid_max", 32'(max_val), 32'd0);
            repeat (2) @(negedge clk);
            rst = 1'b0;
            repeat (10) @(negedge clk);
            check("rstmid_no_done", 32'(done_cnt - dc0), 32'd0);
        end
        run_burst("after_rst", 8'h46, 8'h46, 8'h46, 8'h46, 0, 1'b0, 1'b0,
                  8'h46, 8'h46, 8'h46, 1'b0, 4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
